// File: rtl/irq_capture_ctrl.sv
// Four-line interrupt capture and service controller: synchronises raw requests,
// latches capture events into a pending register and serves one fixed-priority request at a time.
module irq_capture_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [1:0] irq_id,
  output logic [3:0] pending,
  output logic [3:0] in_service
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  sdly_q;
  logic [3:0]                  rise_q;
  logic [3:0]                  rise_d;
  logic [3:0]                  pending_q;
  logic [3:0]                  pending_d;
  logic [3:0]                  clear_vec;
  logic [3:0]                  eligible;
  logic [3:0]                  synced;
  logic                        sel_valid;
  logic [1:0]                  sel_id;

  state_t     state_q;
  logic       irq_q;
  logic [1:0] irq_id_q;
  logic [3:0] in_service_q;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign eligible = pending_q & ~mask;

  // Capture events are registered once more so pending lands SYNC_STAGES+1 edges after sampling.
  always_comb begin
    rise_d = EDGE_MODE ? (synced & ~sdly_q) : synced;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sdly_q <= '0;
      rise_q <= '0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], req};
      end else begin
        sync_q <= req;
      end
      sdly_q <= synced;
      rise_q <= rise_d;
    end
  end

  always_comb begin
    clear_vec = '0;
    if (state_q == REQ && ack) begin
      clear_vec[irq_id_q] = 1'b1;
    end
  end

  // A capture in the same cycle as its acknowledge wins, so the new event is not lost.
  always_comb begin
    pending_d = (pending_q & ~clear_vec) | rise_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    sel_valid = |eligible;
    sel_id    = 2'd0;
    if (eligible[3]) begin
      sel_id = 2'd3;
    end else if (eligible[2]) begin
      sel_id = 2'd2;
    end else if (eligible[1]) begin
      sel_id = 2'd1;
    end
  end

  // irq_id is frozen once presented; it only changes when a new request is issued from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      irq_q        <= 1'b0;
      irq_id_q     <= 2'd0;
      in_service_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            irq_q    <= 1'b1;
            irq_id_q <= sel_id;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            irq_q        <= 1'b0;
            in_service_q <= 4'd1 << irq_id_q;
            state_q      <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            in_service_q <= 4'd0;
            state_q      <= IDLE;
          end
        end
        default: begin
          irq_q        <= 1'b0;
          in_service_q <= 4'd0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign irq        = irq_q;
  assign irq_id     = irq_id_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_capture_ctrl.sv
// Directed bench for irq_capture_ctrl with SYNC_STAGES=2 and EDGE_MODE=1: a vector table
// for the handshake/priority/mask/collision flows plus hand sequences around reset.
module tb_irq_capture_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [1:0] irqId;
  logic [3:0] pending;
  logic [3:0] inService;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic       eoi;
    logic       expIrq;
    logic [1:0] expId;
    logic [3:0] expPending;
    logic [3:0] expInService;
  } vec_t;

  vec_t vecs[$];

  irq_capture_ctrl #(
    .SYNC_STAGES(2),
    .EDGE_MODE(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .mask(mask),
    .ack(ack),
    .eoi(eoi),
    .irq(irq),
    .irq_id(irqId),
    .pending(pending),
    .in_service(inService)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] m, input logic a, input logic e);
    req  = r;
    mask = m;
    ack  = a;
    eoi  = e;
  endtask

  task automatic checkOne(input string name, input string field, input logic [3:0] got, input logic [3:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s %s: got %b expected %b", name, field, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input logic eIrq, input logic [1:0] eId,
                             input logic [3:0] ePend, input logic [3:0] eInS);
    checkOne(name, "irq", {3'b000, irq}, {3'b000, eIrq});
    checkOne(name, "irq_id", {2'b00, irqId}, {2'b00, eId});
    checkOne(name, "pending", pending, ePend);
    checkOne(name, "in_service", inService, eInS);
  endtask

  task automatic addVec(input logic [3:0] r, input logic [3:0] m, input logic a, input logic e,
                        input logic xi, input logic [1:0] xd, input logic [3:0] xp, input logic [3:0] xs);
    vec_t v;
    v.req = r; v.mask = m; v.ack = a; v.eoi = e;
    v.expIrq = xi; v.expId = xd; v.expPending = xp; v.expInService = xs;
    vecs.push_back(v);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // Each row: inputs driven before an edge, outputs expected just after that edge.
    // single request on line 1
    addVec(4'b0010, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 4'b0000);
    addVec(4'b0010, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 4'b0000);
    addVec(4'b0010, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 4'b0000);
    addVec(4'b0000, 4'b0000, 0, 0,  0, 2'd0, 4'b0010, 4'b0000);
    addVec(4'b0000, 4'b0000, 0, 0,  1, 2'd1, 4'b0010, 4'b0000);
    addVec(4'b0000, 4'b0000, 1, 0,  0, 2'd1, 4'b0000, 4'b0010);
    addVec(4'b0000, 4'b0000, 1, 0,  0, 2'd1, 4'b0000, 4'b0010);
    addVec(4'b0000, 4'b0000, 0, 1,  0, 2'd1, 4'b0000, 4'b0000);
    addVec(4'b0000, 4'b0000, 1, 0,  0, 2'd1, 4'b0000, 4'b0000);
    // priority and stability: lines 0 and 2 together, line 3 arrives during REQ
    addVec(4'b0101, 4'b0000, 0, 0,  0, 2'd1, 4'b0000, 4'b0000);
    addVec(4'b0101, 4'b0000, 0, 0,  0, 2'd1, 4'b0000, 4'b0000);
    addVec(4'b0101, 4'b0000, 0, 0,  0, 2'd1, 4'b0000, 4'b0000);
    addVec(4'b0101, 4'b0000, 0, 0,  0, 2'd1, 4'b0101, 4'b0000);
    addVec(4'b1101, 4'b0000, 0, 0,  1, 2'd2, 4'b0101, 4'b0000);
    addVec(4'b1101, 4'b0000, 0, 1,  1, 2'd2, 4'b0101, 4'b0000);
    addVec(4'b1101, 4'b0000, 0, 0,  1, 2'd2, 4'b0101, 4'b0000);
    addVec(4'b1101, 4'b0000, 0, 0,  1, 2'd2, 4'b1101, 4'b0000);
    addVec(4'b0000, 4'b0000, 1, 0,  0, 2'd2, 4'b1001, 4'b0100);
    addVec(4'b0000, 4'b0000, 0, 1,  0, 2'd2, 4'b1001, 4'b0000);
    addVec(4'b0000, 4'b0000, 0, 0,  1, 2'd3, 4'b1001, 4'b0000);
    addVec(4'b0000, 4'b0000, 1, 0,  0, 2'd3, 4'b0001, 4'b1000);
    addVec(4'b0000, 4'b0000, 0, 1,  0, 2'd3, 4'b0001, 4'b0000);
    addVec(4'b0000, 4'b0000, 0, 0,  1, 2'd0, 4'b0001, 4'b0000);
    addVec(4'b0000, 4'b0000, 1, 1,  0, 2'd0, 4'b0000, 4'b0001);
    addVec(4'b0000, 4'b0000, 0, 1,  0, 2'd0, 4'b0000, 4'b0000);
    addVec(4'b0000, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 4'b0000);
    // masking of line 3, mask cleared in IDLE, mask toggled during REQ
    addVec(4'b1010, 4'b1000, 0, 0,  0, 2'd0, 4'b0000, 4'b0000);
    addVec(4'b1010, 4'b1000, 0, 0,  0, 2'd0, 4'b0000, 4'b0000);
    addVec(4'b1010, 4'b1000, 0, 0,  0, 2'd0, 4'b0000, 4'b0000);
    addVec(4'b1010, 4'b1000, 0, 0,  0, 2'd0, 4'b1010, 4'b0000);
    addVec(4'b0000, 4'b1000, 0, 0,  1, 2'd1, 4'b1010, 4'b0000);
    addVec(4'b0000, 4'b1000, 1, 0,  0, 2'd1, 4'b1000, 4'b0010);
    addVec(4'b0000, 4'b1000, 0, 1,  0, 2'd1, 4'b1000, 4'b0000);
    addVec(4'b0000, 4'b1000, 0, 0,  0, 2'd1, 4'b1000, 4'b0000);
    addVec(4'b0000, 4'b0000, 0, 0,  1, 2'd3, 4'b1000, 4'b0000);
    addVec(4'b0000, 4'b1000, 0, 0,  1, 2'd3, 4'b1000, 4'b0000);
    addVec(4'b0000, 4'b0000, 1, 0,  0, 2'd3, 4'b0000, 4'b1000);
    addVec(4'b0000, 4'b0000, 0, 1,  0, 2'd3, 4'b0000, 4'b0000);
    // set/clear collision on line 2
    addVec(4'b0100, 4'b0000, 0, 0,  0, 2'd3, 4'b0000, 4'b0000);
    addVec(4'b0100, 4'b0000, 0, 0,  0, 2'd3, 4'b0000, 4'b0000);
    addVec(4'b0100, 4'b0000, 0, 0,  0, 2'd3, 4'b0000, 4'b0000);
    addVec(4'b0000, 4'b0000, 0, 0,  0, 2'd3, 4'b0100, 4'b0000);
    addVec(4'b0000, 4'b0000, 0, 0,  1, 2'd2, 4'b0100, 4'b0000);
    addVec(4'b0100, 4'b0000, 0, 0,  1, 2'd2, 4'b0100, 4'b0000);
    addVec(4'b0100, 4'b0000, 0, 0,  1, 2'd2, 4'b0100, 4'b0000);
    addVec(4'b0100, 4'b0000, 0, 0,  1, 2'd2, 4'b0100, 4'b0000);
    addVec(4'b0000, 4'b0000, 1, 0,  0, 2'd2, 4'b0100, 4'b0100);
    addVec(4'b0000, 4'b0000, 0, 1,  0, 2'd2, 4'b0100, 4'b0000);
    addVec(4'b0000, 4'b0000, 0, 0,  1, 2'd2, 4'b0100, 4'b0000);
    addVec(4'b0000, 4'b0000, 1, 0,  0, 2'd2, 4'b0000, 4'b0100);
    addVec(4'b0000, 4'b0000, 0, 1,  0, 2'd2, 4'b0000, 4'b0000);

    // reset with all requests held high
    rst_n = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
    #1;
    checkOutput("reset_async", 1'b0, 2'd0, 4'b0000, 4'b0000);
    step();
    step();
    checkOutput("reset_held", 1'b0, 2'd0, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
    end
    checkOutput("post_reset_idle", 1'b0, 2'd0, 4'b0000, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req, vecs[i].mask, vecs[i].ack, vecs[i].eoi);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].expIrq, vecs[i].expId,
                  vecs[i].expPending, vecs[i].expInService);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);

    // build up SERVICE with pending=0011, then reset between clock edges
    applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0);
    step();
    step();
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    step();
    checkOutput("svc_pend", 1'b0, 2'd2, 4'b0011, 4'b0000);
    step();
    checkOutput("svc_irq", 1'b1, 2'd1, 4'b0011, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
    step();
    checkOutput("svc_ack", 1'b0, 2'd1, 4'b0001, 4'b0010);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
    step();
    step();
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    step();
    checkOutput("svc_repend", 1'b0, 2'd1, 4'b0011, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midsvc_reset_async", 1'b0, 2'd0, 4'b0000, 4'b0000);
    step();
    step();
    rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
    step();
    checkOutput("stray_ack", 1'b0, 2'd0, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
    step();
    checkOutput("stray_eoi", 1'b0, 2'd0, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
    end
    checkOutput("final_idle", 1'b0, 2'd0, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
